product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter COUNT, default 4: products per frame; legal range 1..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 clear  input  1  synchronous frame abort; discards the partial sum.
REQ-005 in_valid  input  1  C carries a valid product this cycle.
REQ-006 in_ready  output  1  block accepts a product this cycle.
REQ-007 C  input  8  unsigned product from the upstream 4x4 multiplier (0..225 in use; full range 0..255 legal).
REQ-008 out_valid  output  1  out_sum holds a completed frame sum.
REQ-009 out_ready  input  1  downstream consumes the sum this cycle.
REQ-010 out_sum  output  12  unsigned accumulated sum of COUNT products.
REQ-011 beat_cnt  output  5  number of products accepted in the current frame.

Function
REQ-012 The block SHALL implement a two-state FSM: ACC and DONE.
REQ-013 In ACC: in_ready=1 and out_valid=0.
REQ-014 In DONE: in_ready=0 and out_valid=1.
REQ-015 Accept is defined as in_valid && in_ready; only an accept SHALL change out_sum or beat_cnt in ACC.
REQ-016 On accept: out_sum <= out_sum + zero-extended C (12-bit); beat_cnt <= beat_cnt + 1.
REQ-017 On the accept that brings beat_cnt to COUNT, the FSM SHALL move to DONE; out_valid SHALL rise one cycle after that accept.
REQ-018 Arithmetic: the 12-bit width covers 16*255=4080. No overflow is possible; no saturation or wrap logic is present.
REQ-019 DONE SHALL hold out_sum and beat_cnt stable until out_ready=1.
REQ-020 In DONE with out_ready=1: next cycle out_sum=0, beat_cnt=0, state=ACC, and in_ready=1.
REQ-021 in_ready SHALL be 0 during the handoff cycle, so no product is accepted in the same cycle as the hand-off.
REQ-022 Back-to-back frames SHALL sustain COUNT accepts per (COUNT+1) cycles when out_ready is held high.
REQ-023 in_valid while in DONE SHALL be ignored; upstream holds its product until in_ready=1.
REQ-024 clear=1 in either state: next cycle out_sum=0, beat_cnt=0, state=ACC.
REQ-025 clear SHALL override a simultaneous accept or out_ready; the product offered in that cycle is dropped.
REQ-026 COUNT=1: each accept SHALL produce a frame; out_sum equals C.
REQ-027 out_sum in ACC SHALL expose the running partial sum; it is only meaningful to downstream when out_valid=1.
REQ-028 All outputs SHALL be register-driven, or decoded only from the state register; no combinational path from in_valid/out_ready to outputs.

Reset
REQ-029 reset SHALL take priority over clear and all handshakes.
REQ-030 After reset: state=ACC, out_sum=0, beat_cnt=0, out_valid=0, in_ready=1.
REQ-031 Reset asserted mid-frame or in DONE SHALL discard all partial or pending results.
REQ-032 No product accepted in the cycle reset is high SHALL be counted.

Verification
REQ-033 Basic frame: COUNT=4; accept C=120, 0, 225, 225 on consecutive cycles with out_ready=1 -> out_valid=1 one cycle after the 4th accept with out_sum=570, beat_cnt=4; next cycle out_sum=0, in_ready=1.
REQ-034 Backpressure: complete a frame with out_ready=0 for 5 cycles and in_valid=1 throughout -> in_ready=0 and out_sum stays at its value for all 5 cycles; no extra product counted; release out_ready -> hand-off, then the next frame starts from 0.
REQ-035 Gapped input: in_valid toggles 1,0,1,0,... with C=15 -> frame completes after 4 accepts, out_sum=60; idle cycles change nothing.
REQ-036 Abort: after 2 accepts of C=100, pulse clear together with in_valid (C=50) -> out_sum=0, beat_cnt=0; the C=50 beat is dropped; the following 4 accepts of 1 give out_sum=4.
REQ-037 Reset mid-operation: reset asserted after 3 accepts, and again while in DONE -> each time next cycle out_sum=0, beat_cnt=0, out_valid=0, in_ready=1.
REQ-038 Max value: COUNT=16, 16 accepts of C=255 -> out_sum=4080 with no wrap.

Source files
------------

// File: rtl/product_accumulator.sv
// Frame accumulator: sums COUNT unsigned 8-bit products into a 12-bit total,
// then holds the result in DONE until downstream takes it.
module product_accumulator #(
    parameter int COUNT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  C,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_sum,
    output logic [4:0]  beat_cnt
);

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_DONE = 1'b1;
    localparam logic [4:0] LAST    = 5'(COUNT);

    logic [0:0]  state_q, state_d;
    logic [11:0] sum_q, sum_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        accept;

    assign accept = in_valid && (state_q == ST_ACC);

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        // clear wins over both the accept and the hand-off
        if (clear) begin
            state_d = ST_ACC;
            sum_d   = 12'd0;
            cnt_d   = 5'd0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (accept) begin
                        sum_d = sum_q + {4'd0, C};
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_d == LAST) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: begin
                    if (out_ready) begin
                        state_d = ST_ACC;
                        sum_d   = 12'd0;
                        cnt_d   = 5'd0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ACC;
            sum_q   <= 12'd0;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake outputs are pure decodes of the state register.
    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_DONE);
    assign out_sum   = sum_q;
    assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator at COUNT=4, COUNT=16 and COUNT=1.
module tb_product_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // COUNT=4 instance
    logic        a_rst = 1'b1, a_clr = 1'b0, a_vld = 1'b0, a_ordy = 1'b0;
    logic [7:0]  a_c = 8'd0;
    logic        a_irdy, a_ovld;
    logic [11:0] a_sum;
    logic [4:0]  a_cnt;
    // COUNT=16 instance
    logic        b_rst = 1'b1, b_clr = 1'b0, b_vld = 1'b0, b_ordy = 1'b0;
    logic [7:0]  b_c = 8'd0;
    logic        b_irdy, b_ovld;
    logic [11:0] b_sum;
    logic [4:0]  b_cnt;
    // COUNT=1 instance
    logic        c_rst = 1'b1, c_clr = 1'b0, c_vld = 1'b0, c_ordy = 1'b0;
    logic [7:0]  c_c = 8'd0;
    logic        c_irdy, c_ovld;
    logic [11:0] c_sum;
    logic [4:0]  c_cnt;

    int qa[$];
    int qb[$];
    int qc[$];

    product_accumulator #(.COUNT(4)) dut_a (
        .clk(clk), .reset(a_rst), .clear(a_clr), .in_valid(a_vld), .in_ready(a_irdy),
        .C(a_c), .out_valid(a_ovld), .out_ready(a_ordy), .out_sum(a_sum), .beat_cnt(a_cnt)
    );
    product_accumulator #(.COUNT(16)) dut_b (
        .clk(clk), .reset(b_rst), .clear(b_clr), .in_valid(b_vld), .in_ready(b_irdy),
        .C(b_c), .out_valid(b_ovld), .out_ready(b_ordy), .out_sum(b_sum), .beat_cnt(b_cnt)
    );
    product_accumulator #(.COUNT(1)) dut_c (
        .clk(clk), .reset(c_rst), .clear(c_clr), .in_valid(c_vld), .in_ready(c_irdy),
        .C(c_c), .out_valid(c_ovld), .out_ready(c_ordy), .out_sum(c_sum), .beat_cnt(c_cnt)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string t, input int o_rdy, input int o_vld, input int o_sum,
                             input int o_cnt, input int rdy, input int vld, input int sum, input int cnt);
        chk({t, ".in_ready"}, o_rdy, rdy);
        chk({t, ".out_valid"}, o_vld, vld);
        chk({t, ".out_sum"}, o_sum, sum);
        chk({t, ".beat_cnt"}, o_cnt, cnt);
    endtask

    task automatic cyc_a(input logic v, input logic [7:0] c, input logic ordy, input logic clr);
        a_vld = v; a_c = c; a_ordy = ordy; a_clr = clr;
        @(posedge clk); #1;
    endtask

    task automatic cyc_b(input logic v, input logic [7:0] c, input logic ordy);
        b_vld = v; b_c = c; b_ordy = ordy;
        @(posedge clk); #1;
    endtask

    task automatic cyc_c(input logic v, input logic [7:0] c, input logic ordy);
        c_vld = v; c_c = c; c_ordy = ordy;
        @(posedge clk); #1;
    endtask

    // Consumption monitors: a hand-off happens at the next edge when DONE meets out_ready.
    always @(negedge clk) begin
        if (!a_rst && !a_clr && a_ovld && a_ordy) begin
            if (qa.size() == 0) chk("a.unexpected_frame", 1, 0);
            else begin
                chk("a.frame_sum", a_sum, qa.pop_front());
                chk("a.frame_beats", a_cnt, 4);
            end
        end
        if (!b_rst && !b_clr && b_ovld && b_ordy) begin
            if (qb.size() == 0) chk("b.unexpected_frame", 1, 0);
            else begin
                chk("b.frame_sum", b_sum, qb.pop_front());
                chk("b.frame_beats", b_cnt, 16);
            end
        end
        if (!c_rst && !c_clr && c_ovld && c_ordy) begin
            if (qc.size() == 0) chk("c.unexpected_frame", 1, 0);
            else begin
                chk("c.frame_sum", c_sum, qc.pop_front());
                chk("c.frame_beats", c_cnt, 1);
            end
        end
    end

    initial begin
        // reset, with in_valid high to show nothing is counted
        a_vld = 1'b1; a_c = 8'd9;
        repeat (2) begin @(posedge clk); #1; end
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0; a_vld = 1'b0;
        chk_state("a.reset", a_irdy, a_ovld, a_sum, a_cnt, 1, 0, 0, 0);
        chk_state("b.reset", b_irdy, b_ovld, b_sum, b_cnt, 1, 0, 0, 0);
        chk_state("c.reset", c_irdy, c_ovld, c_sum, c_cnt, 1, 0, 0, 0);

        // basic frame
        qa.push_back(570);
        cyc_a(1, 120, 1, 0);
        chk_state("a.basic1", a_irdy, a_ovld, a_sum, a_cnt, 1, 0, 120, 1);
        cyc_a(1, 0, 1, 0);
        cyc_a(1, 225, 1, 0);
        cyc_a(1, 225, 1, 0);
        chk_state("a.basic_done", a_irdy, a_ovld, a_sum, a_cnt, 0, 1, 570, 4);
        cyc_a(0, 0, 1, 0);
        chk_state("a.basic_handoff", a_irdy, a_ovld, a_sum, a_cnt, 1, 0, 0, 0);

        // backpressure
        qa.push_back(100);
        cyc_a(1, 10, 0, 0); cyc_a(1, 20, 0, 0); cyc_a(1, 30, 0, 0); cyc_a(1, 40, 0, 0);
        for (int i = 0; i < 5; i++) begin
            chk_state($sformatf("a.bp_hold%0d", i), a_irdy, a_ovld, a_sum, a_cnt, 0, 1, 100, 4);
            cyc_a(1, 99, 0, 0);
        end
        chk_state("a.bp_hold5", a_irdy, a_ovld, a_sum, a_cnt, 0, 1, 100, 4);
        cyc_a(1, 99, 1, 0);
        chk_state("a.bp_handoff", a_irdy, a_ovld, a_sum, a_cnt, 1, 0, 0, 0);
        qa.push_back(20);
        cyc_a(1, 5, 1, 0);
        chk_state("a.bp_next1", a_irdy, a_ovld, a_sum, a_cnt, 1, 0, 5, 1);
        cyc_a(1, 5, 1, 0); cyc_a(1, 5, 1, 0); cyc_a(1, 5, 1, 0);
        chk_state("a.bp_next_done", a_irdy, a_ovld, a_sum, a_cnt, 0, 1, 20, 4);
        cyc_a(0, 0, 1, 0);

        // gapped input
        qa.push_back(60);
        for (int i = 0; i < 7; i++) begin
            cyc_a((i % 2) == 0, 15, 1, 0);
            chk_state($sformatf("a.gap%0d", i), a_irdy, a_ovld, a_sum, a_cnt,
                      (i == 6) ? 0 : 1, (i == 6) ? 1 : 0, 15 * ((i + 2) / 2), (i + 2) / 2);
        end
        cyc_a(0, 0, 1, 0);

        // abort with clear, simultaneous product dropped
        cyc_a(1, 100, 1, 0); cyc_a(1, 100, 1, 0);
        chk_state("a.abort_pre", a_irdy, a_ovld, a_sum, a_cnt, 1, 0, 200, 2);
        cyc_a(1, 50, 1, 1);
        chk_state("a.abort_clr", a_irdy, a_ovld, a_sum, a_cnt, 1, 0, 0, 0);
        qa.push_back(4);
        for (int i = 0; i < 4; i++) cyc_a(1, 1, 1, 0);
        chk_state("a.abort_after", a_irdy, a_ovld, a_sum, a_cnt, 0, 1, 4, 4);
        cyc_a(0, 0, 1, 0);

        // clear in DONE overrides out_ready: no frame consumed
        for (int i = 0; i < 4; i++) cyc_a(1, 1, 0, 0);
        cyc_a(0, 0, 1, 1);
        chk_state("a.clr_done", a_irdy, a_ovld, a_sum, a_cnt, 1, 0, 0, 0);

        // reset mid-frame and in DONE
        for (int i = 0; i < 3; i++) cyc_a(1, 7, 1, 0);
        chk_state("a.rst_pre", a_irdy, a_ovld, a_sum, a_cnt, 1, 0, 21, 3);
        a_rst = 1'b1;
        cyc_a(1, 7, 1, 0);
        a_rst = 1'b0;
        chk_state("a.rst_mid", a_irdy, a_ovld, a_sum, a_cnt, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc_a(1, 7, 0, 0);
        chk_state("a.rst_done_pre", a_irdy, a_ovld, a_sum, a_cnt, 0, 1, 28, 4);
        a_rst = 1'b1;
        cyc_a(1, 7, 1, 0);
        a_rst = 1'b0;
        chk_state("a.rst_done", a_irdy, a_ovld, a_sum, a_cnt, 1, 0, 0, 0);

        // back-to-back frames: COUNT accepts per COUNT+1 cycles
        qa.push_back(12); qa.push_back(12);
        for (int k = 0; k < 10; k++) begin
            cyc_a(1, 3, 1, 0);
            chk($sformatf("a.b2b_in_ready%0d", k), a_irdy, (k % 5) != 3);
            chk($sformatf("a.b2b_out_valid%0d", k), a_ovld, (k % 5) == 3);
        end
        cyc_a(0, 0, 0, 0);

        // COUNT=16 maximum value
        qb.push_back(4080);
        for (int i = 0; i < 16; i++) cyc_b(1, 255, 0);
        chk_state("b.max_done", b_irdy, b_ovld, b_sum, b_cnt, 0, 1, 4080, 16);
        cyc_b(0, 0, 1);
        chk_state("b.max_handoff", b_irdy, b_ovld, b_sum, b_cnt, 1, 0, 0, 0);

        // COUNT=1: every accept is a frame
        qc.push_back(37);
        cyc_c(1, 37, 1);
        chk_state("c.one_done", c_irdy, c_ovld, c_sum, c_cnt, 0, 1, 37, 1);
        qc.push_back(200);
        cyc_c(1, 200, 1);
        chk_state("c.one_handoff", c_irdy, c_ovld, c_sum, c_cnt, 1, 0, 0, 0);
        cyc_c(1, 200, 1);
        chk_state("c.two_done", c_irdy, c_ovld, c_sum, c_cnt, 0, 1, 200, 1);
        cyc_c(0, 0, 1);
        chk_state("c.two_handoff", c_irdy, c_ovld, c_sum, c_cnt, 1, 0, 0, 0);

        chk("a.queue_left", qa.size(), 0);
        chk("b.queue_left", qb.size(), 0);
        chk("c.queue_left", qc.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
